anspwm_sched: RTL and testbench
===============================

# anspwm_sched

Sample scheduler and output combiner for the ANS-PWM stage cascade. It buffers incoming 32-bit targets behind a valid/ready handshake and releases one target to the cascade input every PERIOD clocks. After a fixed settle time it snapshots the signed 16-bit partial outputs of all NST stages and sums them on a single time-shared adder. It then emits one signed result per sample period to the final PWM output logic.

## Interface
- NST, 4, number of cascade stages; sizes c_bus and csgn_bus
- LAT, 3, settle cycles between a tgt change and c_bus reflecting it
- PERIOD, 64, clocks per sample; must satisfy PERIOD >= LAT+NST+3
- W, 17+$clog2(NST), result width (derived, not overridable)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- s_data  in  32  target sample from upstream
- s_valid  in  1  s_data valid
- s_ready  out  1  buffer can accept; transfer on s_valid && s_ready
- tgt  out  32  target to first cascade stage (registered)
- c_bus  in  16*NST  stage k magnitude at bits [16k+15:16k]
- csgn_bus  in  NST  stage k sign, 1 = negative
- y  out  W  signed two's-complement sum of all stages (registered)
- y_valid  out  1  one-cycle strobe, y updated
- underrun  out  1  one-cycle strobe, tick found buffer empty
- underrun_seen  out  1  sticky underrun flag, cleared only by reset

## Operation
- Input buffer: 2-entry FIFO. s_ready = (count < 2), combinational from registered count. Push and pop in the same cycle leave count unchanged and preserve order. A word pushed in the pop cycle is not visible to that pop.
- Period counter cnt: free-running 0..PERIOD-1, wraps to 0. tick = (cnt == PERIOD-1).
- FSM states:
  - IDLE: on tick -> LOAD.
  - LOAD, 1 cycle: if the FIFO is non-empty, pop the head into tgt; else hold tgt, pulse underrun, set underrun_seen. -> SETTLE, scnt=0.
  - SETTLE, LAT cycles: in the last cycle, register the snapshot of c_bus and csgn_bus. -> ACC, acc=0, idx=0.
  - ACC, NST cycles: acc += csgn[idx] ? -zext(c[idx]) : zext(c[idx]) from the snapshot; idx++. One adder, one stage per cycle. -> EMIT.
  - EMIT, 1 cycle: y <= acc, y_valid=1. -> IDLE.
- Arithmetic: magnitudes are zero-extended to W before negation. The sum cannot overflow: max |y| = NST*65535.
- A tick cannot arrive outside IDLE, because PERIOD satisfies the constraint above. An implementation may include a simulation-only check for this.
- Reset (synchronous, any state including mid-ACC):
  - Next edge: state=IDLE, cnt=0, FIFO empty, tgt=0, y=0, acc=0, y_valid=0, underrun=0, underrun_seen=0.
  - s_ready=1 from the first cycle after reset.
  - No y_valid is produced for an interrupted sample.

## Timing
- Cycle numbering: cycle 0 is the first cycle with rst_n=1. The first tick is at cycle PERIOD-1, then every PERIOD cycles.
- For a tick at cycle T:
  - LOAD at T+1; new tgt is visible at T+2.
  - Snapshot is sampled in cycle T+1+LAT.
  - ACC runs T+2+LAT through T+1+LAT+NST.
  - y_valid is high in cycle T+2+LAT+NST, with y valid from that cycle.
  - With the defaults, y_valid is at T+9.
- underrun is high in the LOAD cycle T+1. underrun_seen is high from T+2 onward.
- y holds its value between EMIT cycles. tgt holds between LOAD cycles.

## Test plan
- Reset check, bench uses NST=4, LAT=3, PERIOD=16: hold rst_n=0 for 3 cycles, then release -> tgt=0, y=0, y_valid=0, underrun=0, underrun_seen=0, s_ready=1.
- Basic sample: push 0x12345678 at cycle 2; hold c_bus at 100 on all stages, csgn_bus=0 -> tgt=0x12345678 from cycle 17; y_valid only at cycle 24 with y=400.
- Signed sum:
  - c={1000,200,30,4}, csgn={0,1,0,1} (stage 0 first) -> y=826.
  - All stages 65535 with csgn=1111 -> y=-262140 (0x40004 in 19 bits).
- Underrun: no push before the tick at cycle 15 -> underrun high at cycle 16 only, underrun_seen stays 1, tgt unchanged, y_valid still at cycle 24.
- Backpressure: s_valid held high with words A, B, C from cycle 1 -> s_ready low after A and B are accepted. C is accepted in cycle 17, after the pop at cycle 16. tgt shows A at 17 and B at 33; C appears at 49.
- Reset mid-operation: drive rst_n=0 in cycle 21 (ACC) -> all outputs at reset values from cycle 22, no y_valid at cycle 24, first new tick at 15 cycles after release.

Source files
------------

// File: rtl/anspwm_sched.sv
// Sample scheduler and output combiner for the ANS-PWM cascade: buffers targets,
// releases one per period, snapshots all stage outputs and sums them on one adder.
module anspwm_sched #(
  parameter int NST    = 4,
  parameter int LAT    = 3,
  parameter int PERIOD = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [31:0]                 tgt,
  input  logic [16*NST-1:0]           c_bus,
  input  logic [NST-1:0]              csgn_bus,
  output logic [17+$clog2(NST)-1:0]   y,
  output logic                        y_valid,
  output logic                        underrun,
  output logic                        underrun_seen
);

  localparam int W  = 17 + $clog2(NST);
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int IW = (NST > 1) ? $clog2(NST) : 1;
  localparam int SW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, ACC, EMIT} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt;
  logic              tick;
  logic [31:0]       fifo_mem [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count;
  logic              push, pop;
  logic [SW-1:0]     scnt;
  logic [IW-1:0]     idx;
  logic [15:0]       c_arr  [NST];
  logic [15:0]       snap_c [NST];
  logic [NST-1:0]    snap_s;
  logic [W-1:0]      acc, mag, term, acc_sum;
  logic              settle_last, acc_last;

  genvar gi;
  generate
    for (gi = 0; gi < NST; gi++) begin : g_unpack
      assign c_arr[gi] = c_bus[16*gi +: 16];
    end
  endgenerate

  assign tick        = (cnt == CW'(PERIOD - 1));
  assign s_ready     = (count < 2'd2);
  assign push        = s_valid && s_ready;
  assign pop         = (state_reg == LOAD) && (count != 2'd0);
  assign underrun    = (state_reg == LOAD) && (count == 2'd0);
  assign y_valid     = (state_reg == EMIT);
  assign settle_last = (scnt == SW'(LAT - 1));
  assign acc_last    = (idx == IW'(NST - 1));

  // Magnitudes are zero-extended before negation so 65535 never reads as -1.
  assign mag     = {{(W-16){1'b0}}, snap_c[idx]};
  assign term    = snap_s[idx] ? (-mag) : mag;
  assign acc_sum = acc + term;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (tick) state_next = LOAD;
      LOAD:    state_next = SETTLE;
      SETTLE:  if (settle_last) state_next = ACC;
      ACC:     if (acc_last) state_next = EMIT;
      EMIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The buffer array is not reset; only the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (rst_n && push) fifo_mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt           <= '0;
      count         <= '0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      tgt           <= '0;
      y             <= '0;
      acc           <= '0;
      scnt          <= '0;
      idx           <= '0;
      snap_s        <= '0;
      underrun_seen <= 1'b0;
      for (int k = 0; k < NST; k++) snap_c[k] <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        tgt    <= fifo_mem[rd_ptr];
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
      if (underrun) underrun_seen <= 1'b1;

      case (state_reg)
        LOAD: scnt <= '0;
        SETTLE: begin
          scnt <= scnt + SW'(1);
          if (settle_last) begin
            for (int k = 0; k < NST; k++) snap_c[k] <= c_arr[k];
            snap_s <= csgn_bus;
            acc    <= '0;
            idx    <= '0;
          end
        end
        ACC: begin
          acc <= acc_sum;
          idx <= idx + IW'(1);
          // y is loaded with the final sum so it is already valid in the EMIT cycle.
          if (acc_last) y <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_anspwm_sched.sv
// Directed bench for anspwm_sched (NST=4, LAT=3, PERIOD=16); cycle 0 is the
// first cycle with rst_n high, inputs driven and outputs sampled at negedge.
module tb_anspwm_sched;
  localparam int NST = 4, LAT = 3, PERIOD = 16, W = 19;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [31:0]       tgt;
  logic [16*NST-1:0] c_bus = '0;
  logic [NST-1:0]    csgn_bus = '0;
  logic [W-1:0]      y;
  logic              y_valid, underrun, underrun_seen;

  always #5 clk = ~clk;

  anspwm_sched #(.NST(NST), .LAT(LAT), .PERIOD(PERIOD)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .tgt(tgt), .c_bus(c_bus), .csgn_bus(csgn_bus), .y(y), .y_valid(y_valid),
    .underrun(underrun), .underrun_seen(underrun_seen)
  );

  int cyc, n_checks, n_fail;
  int yv_cnt, yv_cyc, ur_cnt, ur_cyc;
  logic feed_en = 1'b0;
  logic [31:0] words [3];
  int wi;
  int acc_cyc [3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s = 0x%0h (cycle %0d)", tag, got, cyc);
    end
  endtask

  // Steps to the negedge of the target cycle, logging strobes and feeding words.
  task automatic advance_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
      if (y_valid === 1'b1) begin yv_cnt++; yv_cyc = cyc; end
      if (underrun === 1'b1) begin ur_cnt++; ur_cyc = cyc; end
      if (feed_en) begin
        if (wi < 3) begin
          s_valid = 1'b1;
          s_data  = words[wi];
          if (s_ready === 1'b1) begin acc_cyc[wi] = cyc; wi++; end
        end else begin
          s_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic clear_mon();
    cyc = 0; yv_cnt = 0; yv_cyc = -1; ur_cnt = 0; ur_cyc = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0; feed_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic set_c(input int c0, input int c1, input int c2, input int c3, input logic [3:0] sg);
    c_bus    = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    csgn_bus = sg;
  endtask

  task automatic push_at(input int at, input logic [31:0] d);
    advance_to(at);
    s_data = d; s_valid = 1'b1;
    advance_to(at + 1);
    s_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    words[0] = 32'hAAAA_0001; words[1] = 32'hBBBB_0002; words[2] = 32'hCCCC_0003;

    // Reset values
    do_reset();
    check("rst_tgt", 64'(tgt), 64'h0);
    check("rst_y", 64'(y), 64'h0);
    check("rst_y_valid", 64'(y_valid), 64'h0);
    check("rst_underrun", 64'(underrun), 64'h0);
    check("rst_underrun_seen", 64'(underrun_seen), 64'h0);
    check("rst_s_ready", 64'(s_ready), 64'h1);

    // Basic sample
    do_reset();
    set_c(100, 100, 100, 100, 4'b0000);
    push_at(2, 32'h1234_5678);
    advance_to(16);
    check("basic_tgt_before", 64'(tgt), 64'h0);
    advance_to(17);
    check("basic_tgt", 64'(tgt), 64'h1234_5678);
    advance_to(23);
    check("basic_no_early_valid", 64'(yv_cnt), 64'd0);
    advance_to(24);
    check("basic_y_valid", 64'(y_valid), 64'h1);
    check("basic_y", 64'(y), 64'd400);
    advance_to(30);
    check("basic_yv_count", 64'(yv_cnt), 64'd1);
    check("basic_y_hold", 64'(y), 64'd400);
    check("basic_no_underrun", 64'(underrun_seen), 64'h0);

    // Signed sums: mixed signs, then full-scale negative on the next period
    do_reset();
    set_c(1000, 200, 30, 4, 4'b1010);
    push_at(2, 32'h0000_0042);
    advance_to(24);
    check("mixed_y", 64'(y), 64'd826);
    advance_to(25);
    set_c(65535, 65535, 65535, 65535, 4'b1111);
    advance_to(40);
    check("neg_y_valid", 64'(y_valid), 64'h1);
    check("neg_y", 64'(y), 64'h40004);
    check("neg_tgt_hold", 64'(tgt), 64'h42);
    check("neg_underrun_seen", 64'(underrun_seen), 64'h1);

    // Underrun: nothing pushed before the first tick
    do_reset();
    set_c(100, 100, 100, 100, 4'b0000);
    advance_to(15);
    check("ur_before", 64'(ur_cnt), 64'd0);
    advance_to(17);
    check("ur_seen", 64'(underrun_seen), 64'h1);
    check("ur_tgt", 64'(tgt), 64'h0);
    advance_to(24);
    check("ur_y_valid", 64'(y_valid), 64'h1);
    check("ur_y", 64'(y), 64'd400);
    advance_to(30);
    check("ur_cycle", 64'(ur_cyc), 64'd16);
    check("ur_count", 64'(ur_cnt), 64'd1);
    check("ur_seen_sticky", 64'(underrun_seen), 64'h1);

    // Backpressure with three words held valid from cycle 1
    do_reset();
    wi = 0;
    feed_en = 1'b1;
    advance_to(3);
    check("bp_ready_full", 64'(s_ready), 64'h0);
    advance_to(17);
    check("bp_tgt_a", 64'(tgt), 64'(words[0]));
    advance_to(33);
    check("bp_tgt_b", 64'(tgt), 64'(words[1]));
    advance_to(48);
    check("bp_tgt_b_hold", 64'(tgt), 64'(words[1]));
    advance_to(49);
    check("bp_tgt_c", 64'(tgt), 64'(words[2]));
    check("bp_acc_a", 64'(acc_cyc[0]), 64'd1);
    check("bp_acc_b", 64'(acc_cyc[1]), 64'd2);
    check("bp_acc_c", 64'(acc_cyc[2]), 64'd17);
    feed_en = 1'b0; s_valid = 1'b0;

    // Reset in the middle of accumulation
    do_reset();
    set_c(100, 100, 100, 100, 4'b0000);
    push_at(2, 32'hCAFE_F00D);
    advance_to(21);
    rst_n = 1'b0;
    advance_to(22);
    rst_n = 1'b1;
    check("mid_tgt", 64'(tgt), 64'h0);
    check("mid_y", 64'(y), 64'h0);
    check("mid_y_valid", 64'(y_valid), 64'h0);
    check("mid_underrun_seen", 64'(underrun_seen), 64'h0);
    check("mid_s_ready", 64'(s_ready), 64'h1);
    clear_mon();
    advance_to(14);
    check("mid_no_stale_valid", 64'(yv_cnt), 64'd0);
    advance_to(24);
    check("mid_ur_cycle", 64'(ur_cyc), 64'd16);
    check("mid_y_valid_new", 64'(y_valid), 64'h1);
    check("mid_y_new", 64'(y), 64'd400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
